tx_deframer: RTL and testbench

- Transmit-direction counterpart of the receive sample packer.
- Reads interleaved 16-bit channel words from the show-ahead read port of the host-to-FPGA transmit FIFO, which the FX2 fills.
- Reassembles each group of words into one parallel sample frame of up to 8 channels, and releases one frame per DSP `strobe` toward the interpolator/DAC path.
- Recognises the window tag word (16'h4000) as a frame-alignment marker. Reports underrun and misalignment through sticky flags.

---
 rtl/tx_deframer.sv | 177 +++++++++++++++++
 tb/tb_tx_deframer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_deframer.sv
// Rebuilds interleaved 16-bit channel words from the TX FIFO into parallel frames of 1..8 channels,
// one frame per strobe. Define TX_DEFRAMER_UNDERRUN_HOLD_EN to hold dout on underrun instead of zeroing.
module tx_deframer #(
  parameter logic [15:0] DATA_TAG     = 16'h4000,
  parameter int unsigned MAX_CHANNELS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        strobe,
  input  logic [3:0]  channels,
  input  logic        clear_status,
  input  logic [15:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  output logic [15:0] dout0,
  output logic [15:0] dout1,
  output logic [15:0] dout2,
  output logic [15:0] dout3,
  output logic [15:0] dout4,
  output logic [15:0] dout5,
  output logic [15:0] dout6,
  output logic [15:0] dout7,
  output logic        sample_valid,
  output logic        window_start,
  output logic        underrun,
  output logic        sync_error
);

  typedef enum logic [1:0] {StIdle, StFill, StReady} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  nch_q, nch_d, nch_eff, ch_sat;
  logic [15:0] shadow_q [8];
  logic [15:0] shadow_d [8];
  logic [15:0] dout_q [8];
  logic [15:0] dout_d [8];
  logic        tag_pending_q, tag_pending_d;
  logic        sample_valid_q, sample_valid_d;
  logic        window_start_q, window_start_d;
  logic        underrun_q, underrun_d;
  logic        sync_error_q, sync_error_d;

  always_comb begin
    if (channels == 4'd0) begin
      ch_sat = 4'd1;
    end else if (channels > 4'(MAX_CHANNELS)) begin
      ch_sat = 4'(MAX_CHANNELS);
    end else begin
      ch_sat = channels;
    end
    // The channel count stays live until the first word of a frame is written.
    nch_eff = (state_q == StFill && idx_q == 3'd0) ? ch_sat : nch_q;
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    nch_d          = nch_q;
    shadow_d       = shadow_q;
    dout_d         = dout_q;
    tag_pending_d  = tag_pending_q;
    sample_valid_d = 1'b0;
    window_start_d = 1'b0;
    underrun_d     = underrun_q & ~clear_status;
    sync_error_d   = sync_error_q & ~clear_status;
    fifo_rdreq     = 1'b0;

    if (!enable) begin
      state_d       = StIdle;
      idx_d         = 3'd0;
      tag_pending_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StFill;
          idx_d   = 3'd0;
        end
        StFill: begin
          fifo_rdreq = ~fifo_empty;
          nch_d      = nch_eff;
          if (!fifo_empty) begin
            if (fifo_data == DATA_TAG) begin
              if (idx_q != 3'd0) begin
                sync_error_d = 1'b1;
              end
              tag_pending_d = 1'b1;
              idx_d         = 3'd0;
            end else begin
              shadow_d[idx_q] = fifo_data;
              if ({1'b0, idx_q} == nch_eff - 4'd1) begin
                state_d = StReady;
                idx_d   = 3'd0;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end
          end
        end
        StReady: begin
          if (strobe) begin
            for (int i = 0; i < 8; i++) begin
              dout_d[i] = (i < int'(nch_q)) ? shadow_q[i] : 16'h0000;
            end
            sample_valid_d = 1'b1;
            window_start_d = tag_pending_q;
            tag_pending_d  = 1'b0;
            state_d        = StFill;
            idx_d          = 3'd0;
          end
        end
        default: state_d = StIdle;
      endcase

      if (strobe && state_q != StReady) begin
        underrun_d     = 1'b1;
        sample_valid_d = 1'b1;
`ifdef TX_DEFRAMER_UNDERRUN_HOLD_EN
        dout_d         = dout_q;
`else
        for (int i = 0; i < 8; i++) begin
          dout_d[i] = 16'h0000;
        end
`endif
      end
    end

    if (reset) begin
      fifo_rdreq = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= 3'd0;
      nch_q          <= 4'd1;
      tag_pending_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      window_start_q <= 1'b0;
      underrun_q     <= 1'b0;
      sync_error_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= 16'h0000;
        dout_q[i]   <= 16'h0000;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      nch_q          <= nch_d;
      tag_pending_q  <= tag_pending_d;
      sample_valid_q <= sample_valid_d;
      window_start_q <= window_start_d;
      underrun_q     <= underrun_d;
      sync_error_q   <= sync_error_d;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= shadow_d[i];
        dout_q[i]   <= dout_d[i];
      end
    end
  end

  assign dout0        = dout_q[0];
  assign dout1        = dout_q[1];
  assign dout2        = dout_q[2];
  assign dout3        = dout_q[3];
  assign dout4        = dout_q[4];
  assign dout5        = dout_q[5];
  assign dout6        = dout_q[6];
  assign dout7        = dout_q[7];
  assign sample_valid = sample_valid_q;
  assign window_start = window_start_q;
  assign underrun     = underrun_q;
  assign sync_error   = sync_error_q;

endmodule

// File: tb/tb_tx_deframer.sv
// Directed bench for tx_deframer with a queue-backed show-ahead FIFO model.
module tb_tx_deframer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        strobe = 1'b0;
  logic [3:0]  channels = 4'd1;
  logic        clear_status = 1'b0;
  logic [15:0] fifo_data = 16'h0000;
  logic        fifo_empty = 1'b1;
  logic        fifo_rdreq;
  logic [15:0] dout [8];
  logic        sample_valid, window_start, underrun, sync_error;

  logic [15:0] fifo_q [$];
  logic [15:0] exp_d [8];
  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;

  always #5 clk = ~clk;

  tx_deframer dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .strobe      (strobe),
    .channels    (channels),
    .clear_status(clear_status),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_rdreq  (fifo_rdreq),
    .dout0       (dout[0]),
    .dout1       (dout[1]),
    .dout2       (dout[2]),
    .dout3       (dout[3]),
    .dout4       (dout[4]),
    .dout5       (dout[5]),
    .dout6       (dout[6]),
    .dout7       (dout[7]),
    .sample_valid(sample_valid),
    .window_start(window_start),
    .underrun    (underrun),
    .sync_error  (sync_error)
  );

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 16'h0000 : fifo_q[0];
  endtask

  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // One clock: rdreq sampled mid-cycle, head popped just after the edge.
  task automatic tick();
    logic rd;
    @(negedge clk);
    rd = fifo_rdreq;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      consumed++;
    end
    refresh();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_strobe();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic test_reset();
    ticks(2);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout[i] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_dout%0d: got %h want 0000", i, dout[i]);
      end
    end
    checks++;
    if ({sample_valid, window_start, underrun, sync_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {sample_valid, window_start, underrun, sync_error});
    end
    push(16'h4000); push(16'h0011); push(16'h0022);
    enable = 1'b1; channels = 4'd2;
    #1;
    checks++;
    if (fifo_rdreq !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdreq: got %b want 0", fifo_rdreq);
    end
  endtask

  task automatic test_basic_frame();
    reset = 1'b0;
    ticks(6);
    pulse_strobe();
    exp_d = '{16'h0011, 16'h0022, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_dout%0d: got %h want %h", i, dout[i], exp_d[i]);
      end
    end
    checks++;
    if ({sample_valid, window_start, underrun} !== 3'b110) begin
      errors++;
      $display("FAIL basic_pulses: got %b want 110", {sample_valid, window_start, underrun});
    end
    checks++;
    if (consumed !== 3) begin
      errors++;
      $display("FAIL basic_consumed: got %0d want 3", consumed);
    end
    tick();
    checks++;
    if ({sample_valid, window_start} !== 2'b00) begin
      errors++;
      $display("FAIL basic_pulse_end: got %b want 00", {sample_valid, window_start});
    end
  endtask

  task automatic test_underrun();
    channels = 4'd4;
    tick();
    pulse_strobe();
`ifdef TX_DEFRAMER_UNDERRUN_HOLD_EN
    exp_d = '{16'h0011, 16'h0022, 0, 0, 0, 0, 0, 0};
`else
    exp_d = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL underrun_dout%0d: got %h want %h", i, dout[i], exp_d[i]);
      end
    end
    checks++;
    if ({underrun, sample_valid} !== 2'b11) begin
      errors++;
      $display("FAIL underrun_set: got %b want 11", {underrun, sample_valid});
    end
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: got %b want 0", underrun);
    end
  endtask

  task automatic test_sync_error();
    channels = 4'd3;
    push(16'h0001); push(16'h0002); push(16'h4000);
    push(16'h000A); push(16'h000B); push(16'h000C);
    ticks(10);
    pulse_strobe();
    exp_d = '{16'h000A, 16'h000B, 16'h000C, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL sync_dout%0d: got %h want %h", i, dout[i], exp_d[i]);
      end
    end
    checks++;
    if ({sync_error, window_start, sample_valid, underrun} !== 4'b1110) begin
      errors++;
      $display("FAIL sync_flags: got %b want 1110",
               {sync_error, window_start, sample_valid, underrun});
    end
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    checks++;
    if (sync_error !== 1'b0) begin
      errors++;
      $display("FAIL sync_clear: got %b want 0", sync_error);
    end
  endtask

  task automatic test_channel_limits();
    channels = 4'd0;
    push(16'h0055);
    ticks(4);
    pulse_strobe();
    exp_d = '{16'h0055, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL ch0_dout%0d: got %h want %h", i, dout[i], exp_d[i]);
      end
    end
    checks++;
    if ({sample_valid, window_start, underrun} !== 3'b100) begin
      errors++;
      $display("FAIL ch0_pulses: got %b want 100", {sample_valid, window_start, underrun});
    end
    channels = 4'd9;
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
    ticks(12);
    pulse_strobe();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout[i] !== 16'h0100 + 16'(i)) begin
        errors++;
        $display("FAIL ch9_dout%0d: got %h want %h", i, dout[i], 16'h0100 + 16'(i));
      end
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL ch9_underrun: got %b want 0", underrun);
    end
  endtask

  task automatic test_reset_midframe();
    channels = 4'd4;
    push(16'hDEAD); push(16'hBEEF);
    ticks(4);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    checks++;
    if (dout[0] !== 16'h0000 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: got dout0=%h underrun=%b want 0000/0", dout[0], underrun);
    end
    for (int i = 0; i < 4; i++) push(16'h0A01 + 16'(i));
    ticks(8);
    pulse_strobe();
    exp_d = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL midreset_dout%0d: got %h want %h", i, dout[i], exp_d[i]);
      end
    end
    checks++;
    if ({sample_valid, window_start, underrun} !== 3'b100) begin
      errors++;
      $display("FAIL midreset_pulses: got %b want 100", {sample_valid, window_start, underrun});
    end
  endtask

  task automatic test_strobe_on_last_word();
    channels = 4'd2;
    push(16'h0B01);
    ticks(3);
    push(16'h0B02);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
`ifdef TX_DEFRAMER_UNDERRUN_HOLD_EN
    exp_d = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 0, 0, 0, 0};
`else
    exp_d = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    checks++;
    if ({underrun, sample_valid} !== 2'b11) begin
      errors++;
      $display("FAIL late_underrun: got %b want 11", {underrun, sample_valid});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL late_dout%0d: got %h want %h", i, dout[i], exp_d[i]);
      end
    end
    tick();
    pulse_strobe();
    checks++;
    if (dout[0] !== 16'h0B01 || dout[1] !== 16'h0B02 || dout[2] !== 16'h0000) begin
      errors++;
      $display("FAIL late_frame: got %h %h %h want 0b01 0b02 0000", dout[0], dout[1], dout[2]);
    end
    checks++;
    if (sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL late_valid: got %b want 1", sample_valid);
    end
  endtask

  task automatic test_enable_low();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    enable = 1'b0;
    tick();
    pulse_strobe();
    checks++;
    if ({underrun, sample_valid} !== 2'b00) begin
      errors++;
      $display("FAIL disabled_strobe: got %b want 00", {underrun, sample_valid});
    end
    push(16'h0123);
    #1;
    checks++;
    if (fifo_rdreq !== 1'b0) begin
      errors++;
      $display("FAIL disabled_rdreq: got %b want 0", fifo_rdreq);
    end
  endtask

  initial begin
    refresh();
    test_reset();
    test_basic_frame();
    test_underrun();
    test_sync_error();
    test_channel_limits();
    test_reset_midframe();
    test_strobe_on_last_word();
    test_enable_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
